ultrasound_sweep_scheduler: RTL
===============================

# ultrasound_sweep_scheduler

Sequences the ultrasound range-finding sweep: steps the servo through five fixed angular positions (index 1..5, 15°..75°), waits for mechanical settle, triggers one measurement per position and tracks the nearest echo. Sits between the top-level control FSM (start/result) and the servo PWM and ultrasound ranging modules. Replaces an end-of-sweep combinational minimum search with a running minimum updated as each distance arrives.

## Interface
- SETTLE_CYCLES, 2_700_000: cycles to wait after each servo move (100 ms at 27 MHz); must be ≥1.
- MEAS_TIMEOUT, 1_350_000: max cycles in WAIT before the position is declared a miss; must be ≥1.
- clock  in  1  system clock; single clock domain.
- reset  in  1  asynchronous, active-high; all state and outputs return to reset values immediately.
- start  in  1  request a sweep; sampled only in IDLE.
- meas_done  in  1  one-cycle pulse from the ranging module; meas_dist is valid in the same cycle.
- meas_dist  in  8  measured distance, unsigned.
- servo_pos  out  3  commanded position, 1..5.
- meas_trigger  out  1  one-cycle measurement request.
- busy  out  1  high from the cycle after start is accepted through the DONE cycle.
- result_valid  out  1  one-cycle pulse in DONE.
- min_index  out  3  1-based index of the nearest position; held until the next DONE.
- min_dist  out  8  distance at min_index; held until the next DONE.

## Operation
- States: IDLE, MOVE, SETTLE, TRIG, WAIT, UPDATE, DONE.
- IDLE: on start=1, set pos=1, clear run_min=8'hFF and run_idx=1, then go to MOVE.
- MOVE (1 cycle): drive servo_pos=pos, load timer with SETTLE_CYCLES, go to SETTLE.
- SETTLE: decrement the timer; when it reaches 0, go to TRIG.
- TRIG (1 cycle): meas_trigger=1, load timer with MEAS_TIMEOUT, go to WAIT.
- WAIT: on meas_done, capture d=meas_dist and go to UPDATE. On timer expiry without meas_done, capture d=8'hFF (miss) and go to UPDATE. If meas_done coincides with expiry, meas_done wins.
- UPDATE (1 cycle): if d < run_min (strict), set run_min=d and run_idx=pos. If pos==5, go to DONE; otherwise increment pos and go to MOVE.
- DONE (1 cycle): result_valid=1, min_index=run_idx, min_dist=run_min, go to IDLE. servo_pos stays at 5.
- Ties keep the lower index. If every position misses, the result is index 1, dist 8'hFF.
- meas_done outside WAIT is ignored. start outside IDLE is ignored (no queuing).
- Comparisons are unsigned 8-bit. The timer width is ceil(log2(max(SETTLE_CYCLES, MEAS_TIMEOUT)+1)).

## Timing
- Reset values: servo_pos=1, meas_trigger=0, busy=0, result_valid=0, min_index=0, min_dist=0, state IDLE.
- Start accepted at edge t: MOVE is active in cycle t+1 with busy=1. meas_trigger is high exactly SETTLE_CYCLES+1 cycles after MOVE.
- Per position: 1 (MOVE) + SETTLE_CYCLES + 1 (TRIG) + W + 1 (UPDATE). W is the count of WAIT cycles up to and including the cycle where meas_done is seen, 1..MEAS_TIMEOUT.
- result_valid asserts one cycle after the fifth UPDATE. min_index and min_dist update on the same edge.
- Reset mid-sweep aborts with no result_valid. min_index and min_dist return to 0.
- The earliest start accepted after DONE is in the IDLE cycle that follows.

## Structure
- Shared header phone_home_params.vh holds: NUM_POS=5, MISS_DIST=8'hFF, and the state encodings. The servo angle mapping already shared with the servo module stays there.
- Sub-module cycle_timer: a loadable down-counter with a zero flag, reused for both settle and timeout. All remaining logic is one FSM module.

## Test plan
Parameters SETTLE_CYCLES=4, MEAS_TIMEOUT=16 for all scenarios.
- Distances 40,30,20,10,5 returned 3 cycles after each trigger -> index 5, dist 5; exactly 5 trigger pulses; each trigger 5 cycles after MOVE.
- Distances 50,20,20,90,20 -> index 2, dist 20 (tie keeps the lower index).
- No meas_done at position 3, others 60,70,_,80,90 -> position 3 times out after 16 WAIT cycles; result index 1, dist 60. All positions silent -> index 1, dist 255.
- meas_done on the exact expiry cycle with dist 7 -> 7 is used, not 255.
- start pulsed during SETTLE, and meas_done pulsed during SETTLE -> both ignored; sweep timing unchanged.
- reset asserted during WAIT at position 4 -> outputs return to reset values asynchronously, no result_valid. A new start then runs a full clean sweep from position 1.

Source files
------------

// File: rtl/ultrasound_sweep_scheduler_pkg.sv
// Shared constants and state encoding for the ultrasound sweep scheduler.
// The timer width helper sizes the settle/timeout counter.
package ultrasound_sweep_scheduler_pkg;

    localparam int         NUM_POS   = 5;
    localparam logic [7:0] MISS_DIST = 8'hFF;

    typedef enum logic [2:0] {
        IDLE,
        MOVE,
        SETTLE,
        TRIG,
        WAIT,
        UPDATE,
        DONE
    } sweep_state_t;

    function automatic int timer_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/ultrasound_sweep_scheduler_cycle_timer.sv
// Loadable down-counter with a zero flag.
// Shared between the servo settle wait and the measurement timeout.
module cycle_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/ultrasound_sweep_scheduler.sv
// Steps the servo through five positions, triggers one measurement per
// position and keeps a running minimum of the returned distances.
module ultrasound_sweep_scheduler
    import ultrasound_sweep_scheduler_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2_700_000,
    parameter int MEAS_TIMEOUT  = 1_350_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       meas_done,
    input  logic [7:0] meas_dist,
    output logic [2:0] servo_pos,
    output logic       meas_trigger,
    output logic       busy,
    output logic       result_valid,
    output logic [2:0] min_index,
    output logic [7:0] min_dist
);

    localparam int TIMER_W = timer_width(SETTLE_CYCLES, MEAS_TIMEOUT);
    // The timer is loaded with N-1 so that the zero cycle is the Nth cycle of the wait.
    localparam logic [TIMER_W-1:0] SETTLE_LOAD  = TIMER_W'(SETTLE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMEOUT_LOAD = TIMER_W'(MEAS_TIMEOUT - 1);
    localparam logic [2:0]         LAST_POS     = 3'(NUM_POS);

    sweep_state_t       state, next_state;
    logic [2:0]         pos;
    logic [2:0]         run_idx;
    logic [7:0]         run_min;
    logic [7:0]         dist_q;
    logic               take_new;
    logic [2:0]         upd_idx;
    logic [7:0]         upd_min;
    logic               timer_load;
    logic [TIMER_W-1:0] timer_value;
    logic               timer_zero;

    cycle_timer #(
        .WIDTH(TIMER_W)
    ) u_timer (
        .clock      (clock),
        .reset      (reset),
        .load       (timer_load),
        .load_value (timer_value),
        .zero       (timer_zero)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = MOVE;
            MOVE:    next_state = SETTLE;
            SETTLE:  if (timer_zero) next_state = TRIG;
            TRIG:    next_state = WAIT;
            WAIT:    if (meas_done || timer_zero) next_state = UPDATE;
            UPDATE:  next_state = (pos == LAST_POS) ? DONE : MOVE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        meas_trigger = 1'b0;
        result_valid = 1'b0;
        busy         = (state != IDLE);
        timer_load   = 1'b0;
        timer_value  = SETTLE_LOAD;
        case (state)
            MOVE: timer_load = 1'b1;
            TRIG: begin
                meas_trigger = 1'b1;
                timer_load   = 1'b1;
                timer_value  = TIMEOUT_LOAD;
            end
            DONE:    result_valid = 1'b1;
            default: ;
        endcase
    end

    // Strict less-than so that ties keep the earlier (lower) index.
    assign take_new = (dist_q < run_min);
    assign upd_min  = take_new ? dist_q : run_min;
    assign upd_idx  = take_new ? pos : run_idx;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pos       <= 3'd1;
            run_min   <= MISS_DIST;
            run_idx   <= 3'd1;
            dist_q    <= 8'd0;
            min_index <= 3'd0;
            min_dist  <= 8'd0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    pos     <= 3'd1;
                    run_min <= MISS_DIST;
                    run_idx <= 3'd1;
                end
                WAIT: begin
                    if (meas_done) begin
                        dist_q <= meas_dist;
                    end else if (timer_zero) begin
                        dist_q <= MISS_DIST;
                    end
                end
                // Publishing on the last UPDATE makes the result visible during DONE.
                UPDATE: begin
                    run_min <= upd_min;
                    run_idx <= upd_idx;
                    if (pos == LAST_POS) begin
                        min_index <= upd_idx;
                        min_dist  <= upd_min;
                    end else begin
                        pos <= pos + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign servo_pos = pos;

endmodule
